// File: rtl/jtpopeye_dma_pkg.sv
// Shared types and sizes for the Popeye sprite-RAM DMA initiator.
package jtpopeye_dma_pkg;

  localparam int unsigned DMA_AW  = 10;
  localparam int unsigned DMA_LEN = 1024;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    REL
  } dma_state_t;

endpackage

// File: rtl/jtpopeye_dma_if.sv
// Main-board bus handshake, DMA RAM port and object-buffer write port.
interface jtpopeye_dma_if;
  import jtpopeye_dma_pkg::*;

  logic              busrq_n;
  logic              busak_n;
  logic              dma_cs;
  logic [DMA_AW-1:0] AD_DMA;
  logic [7:0]        DD_DMA;
  logic [DMA_AW-1:0] obj_addr;
  logic [7:0]        obj_data;
  logic              obj_we;

  modport master (
    output busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we,
    input  busak_n, DD_DMA
  );

  modport slave (
    input  busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we,
    output busak_n, DD_DMA
  );

endinterface

// File: rtl/jtpopeye_dma.sv
// Copies main-board sprite RAM into the object buffer on every VB rising edge.
// Optional bus-request timeout: define JTPOPEYE_DMA_TIMEOUT_EN.
module jtpopeye_dma
  import jtpopeye_dma_pkg::*;
#(
  parameter int unsigned LEN    = DMA_LEN,
  parameter int unsigned RD_LAT = 2
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 4095
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           VB,
  jtpopeye_dma_if.master bus,
  output logic           dma_busy,
  output logic           dma_abort
);

  localparam int unsigned       LW      = $clog2(RD_LAT + 2);
  localparam logic [LW-1:0]     LAT_END = LW'(RD_LAT);
  localparam logic [DMA_AW-1:0] LAST    = DMA_AW'(LEN - 1);

  dma_state_t    st;
  logic          VBl;
  logic          trig;
  logic [LW-1:0] lat;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
`endif

  assign trig = VB & ~VBl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      VBl          <= 1'b0;
      lat          <= '0;
      bus.busrq_n  <= 1'b1;
      bus.dma_cs   <= 1'b0;
      bus.AD_DMA   <= '0;
      bus.obj_addr <= '0;
      bus.obj_data <= '0;
      bus.obj_we   <= 1'b0;
      dma_busy     <= 1'b0;
      dma_abort    <= 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      VBl        <= VB;
      bus.obj_we <= 1'b0;
      dma_abort  <= 1'b0;
      case (st)
        IDLE: begin
          // Only the trigger matters here; busak_n changes are ignored.
          if (trig) begin
            st          <= REQ;
            bus.busrq_n <= 1'b0;
            dma_busy    <= 1'b1;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        REQ: begin
          if (cen) begin
            if (!bus.busak_n) begin
              st         <= XFER;
              bus.dma_cs <= 1'b1;
              bus.AD_DMA <= '0;
              lat        <= '0;
            end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            else if (to_cnt == TO_END) begin
              st          <= IDLE;
              bus.busrq_n <= 1'b1;
              dma_busy    <= 1'b0;
              dma_abort   <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
`endif
          end
        end
        XFER: begin
          if (bus.busak_n) begin
            // Bus lost: drop the request, keep whatever was already written.
            st          <= IDLE;
            bus.busrq_n <= 1'b1;
            bus.dma_cs  <= 1'b0;
            dma_busy    <= 1'b0;
            dma_abort   <= 1'b1;
          end else if (lat != LAT_END) begin
            lat <= lat + 1'b1;
          end else begin
            lat          <= '0;
            bus.obj_we   <= 1'b1;
            bus.obj_addr <= bus.AD_DMA;
            bus.obj_data <= bus.DD_DMA;
            bus.AD_DMA   <= bus.AD_DMA + 1'b1;
            if (bus.AD_DMA == LAST) st <= REL;
          end
        end
        REL: begin
          bus.busrq_n <= 1'b1;
          bus.dma_cs  <= 1'b0;
          if (bus.busak_n) begin
            st       <= IDLE;
            dma_busy <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: default instance plus a LEN=4/RD_LAT=1 instance.
module tb_jtpopeye_dma;
  import jtpopeye_dma_pkg::*;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_t;

  localparam logic [32:0] RST_VEC = {1'b1, 32'd0};

  logic clk = 1'b0;
  logic rst;
  logic cen = 1'b0;
  logic vb = 1'b0;
  logic vb_s = 1'b0;
  logic busy, abort, busy_s, abort_s;

  int unsigned cyc = 0;
  int unsigned cdiv = 0;
  logic        cen_seen = 1'b0;
  int          passed = 0;
  int          total = 0;
  bit          abort_s_seen = 0;

  byte unsigned mem   [1024];
  byte unsigned mem_s [1024];
  logic [9:0]   a1;
  wr_t          wq[$];
  wr_t          wq_s[$];

  jtpopeye_dma_if bus ();
  jtpopeye_dma_if bus_s ();

  jtpopeye_dma dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .VB       (vb),
    .bus      (bus),
    .dma_busy (busy),
    .dma_abort(abort)
  );

  jtpopeye_dma #(
    .LEN   (4),
    .RD_LAT(1)
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .VB       (vb_s),
    .bus      (bus_s),
    .dma_busy (busy_s),
    .dma_abort(abort_s)
  );

  always #5 clk = ~clk;

  // Cycle count, cen as seen at each edge, and registered main-RAM read paths.
  always @(posedge clk) begin
    cyc            <= cyc + 1;
    cen_seen       <= cen;
    a1             <= bus.AD_DMA;
    bus.DD_DMA     <= mem[a1];
    bus_s.DD_DMA   <= mem_s[bus_s.AD_DMA];
  end

  always @(negedge clk) begin
    cdiv = cdiv + 1;
    cen  = (cdiv % 4 == 0);
    if (bus.obj_we === 1'b1)
      wq.push_back('{32'(bus.obj_addr), 32'(bus.obj_data), cyc});
    if (bus_s.obj_we === 1'b1)
      wq_s.push_back('{32'(bus_s.obj_addr), 32'(bus_s.obj_data), cyc});
    if (abort_s === 1'b1) abort_s_seen = 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic logic [32:0] rst_vec();
    return {bus.busrq_n, bus.dma_cs, bus.AD_DMA, bus.obj_addr, bus.obj_data,
            bus.obj_we, busy, abort};
  endfunction

  // Wait for the request, grant after cen_delay cen ticks, return the XFER entry cycle.
  task automatic start_xfer(input int cen_delay, output int unsigned t_x);
    int n;
    int k;
    n = 0;
    while (bus.busrq_n !== 1'b0 && n < 10) begin step(); n++; end
    k = 0;
    while (k < cen_delay) begin step(); if (cen_seen) k++; end
    bus.busak_n = 1'b0;
    n = 0;
    while (bus.dma_cs !== 1'b1 && n < 16) begin step(); n++; end
    t_x = cyc;
  endtask

  task automatic verify_xfer(input string tag, input wr_t q[$], input byte unsigned m [1024],
                             input int len, input int lat, input int unsigned t_x);
    int bad_addr = 0;
    int bad_data = 0;
    int bad_gap  = 0;
    check({tag, "_count"}, q.size(), len);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].addr != (i % 1024)) bad_addr++;
      if (q[i].data != 32'(m[i % 1024])) bad_data++;
      if (i > 0 && q[i].cyc - q[i-1].cyc != lat + 1) bad_gap++;
    end
    if (q.size() > 0) check({tag, "_first_we"}, q[0].cyc, t_x + lat + 1);
    check({tag, "_addr_seq"}, bad_addr, 0);
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_spacing"}, bad_gap, 0);
  endtask

  initial begin
    int n;
    int ticks;
    int unsigned t_x;
    int unsigned t_rel;

    rst = 1'b1;
    bus.busak_n = 1'b1;
    bus_s.busak_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 8'(i);
      mem_s[i] = 8'($urandom);
    end
    steps(3);
    check("reset_outputs", rst_vec(), RST_VEC);
    check("reset_small", {bus_s.busrq_n, bus_s.dma_cs, busy_s, abort_s}, 4'b1000);
    rst = 1'b0;
    steps(2);

    // Full transfer with data = addr[7:0], grant 5 cen ticks after request
    vb = 1'b1;
    step();
    check("req_1clk", bus.busrq_n, 0);
    check("busy_set", busy, 1);
    start_xfer(5, t_x);
    check("cs_on_cen_edge", cen_seen, 1);
    check("ad_start", bus.AD_DMA, 0);
    steps(200);
    vb = 1'b0;
    steps(3);
    vb = 1'b1;
    steps(3);
    n = 0;
    while (bus.busrq_n !== 1'b1 && n < 4000) begin step(); n++; end
    t_rel = cyc;
    verify_xfer("full", wq, mem, 1024, 2, t_x);
    check("full_xfer_len", t_rel - t_x, 1024 * 3 + 1);
    check("rel_after_last", t_rel, wq[wq.size()-1].cyc + 1);
    steps(2);
    bus.busak_n = 1'b1;
    step();
    check("busy_drop", {busy, bus.dma_cs}, 2'b00);
    steps(10);
    check("no_queued_trig", {bus.busrq_n, busy}, 2'b10);
    check("count_after_idle", wq.size(), 1024);
    vb = 1'b0;

    // Bus lost after 100 writes, random RAM
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    wq.delete();
    steps(2);
    vb = 1'b1;
    start_xfer(1, t_x);
    n = 0;
    while (wq.size() < 100 && n < 1000) begin step(); n++; end
    bus.busak_n = 1'b1;
    step();
    check("abort_pulse", {abort, bus.busrq_n, bus.dma_cs, busy, bus.obj_we}, 5'b11000);
    step();
    check("abort_one_clk", abort, 0);
    steps(20);
    verify_xfer("abort", wq, mem, 100, 2, t_x);
    vb = 1'b0;

    // Asynchronous reset just after address 0x200 is written
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    wq.delete();
    steps(2);
    vb = 1'b1;
    start_xfer(2, t_x);
    n = 0;
    while (wq.size() < 'h201 && n < 3000) begin step(); n++; end
    rst = 1'b1;
    #1;
    check("reset_async", rst_vec(), RST_VEC);
    vb = 1'b0;
    bus.busak_n = 1'b1;
    step();
    rst = 1'b0;
    steps(3);
    wq.delete();
    vb = 1'b1;
    start_xfer(1, t_x);
    n = 0;
    while (bus.busrq_n !== 1'b1 && n < 4000) begin step(); n++; end
    verify_xfer("restart", wq, mem, 1024, 2, t_x);
    bus.busak_n = 1'b1;
    step();
    vb = 1'b0;

    // Short instance: LEN=4, RD_LAT=1
    vb_s = 1'b1;
    step();
    check("s_req", {bus_s.busrq_n, busy_s}, 2'b01);
    bus_s.busak_n = 1'b0;
    n = 0;
    while (bus_s.dma_cs !== 1'b1 && n < 16) begin step(); n++; end
    t_x = cyc;
    n = 0;
    while (bus_s.busrq_n !== 1'b1 && n < 50) begin step(); n++; end
    verify_xfer("short", wq_s, mem_s, 4, 1, t_x);
    check("short_rel", cyc, t_x + 9);
    bus_s.busak_n = 1'b1;
    step();
    check("short_idle", busy_s, 0);
    vb_s = 1'b0;
    steps(3);

    // Request never granted
    abort_s_seen = 0;
    vb_s = 1'b1;
    step();
    check("s_req2", bus_s.busrq_n, 0);
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    n = 0;
    ticks = 0;
    while (abort_s !== 1'b1 && n < 300) begin
      step();
      n++;
      if (cen_seen) ticks++;
    end
    check("timeout_ticks", ticks, 16);
    check("timeout_release", {bus_s.busrq_n, busy_s, abort_s}, 3'b101);
`else
    ticks = 0;
    steps(300);
    check("no_timeout", {bus_s.busrq_n, busy_s, abort_s_seen}, 3'b010);
    bus_s.busak_n = 1'b0;
    n = 0;
    while (bus_s.busrq_n !== 1'b1 && n < 50) begin step(); n++; end
    bus_s.busak_n = 1'b1;
    step();
    check("late_grant_done", {busy_s, bus_s.busrq_n}, 2'b01);
`endif
    vb_s = 1'b0;
    steps(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
